// File: rtl/transfer_pkg.sv
// Shared constants for the transfer-in path: control header bytes and feeder pacer states.
package transfer_pkg;

    localparam logic [7:0] TRANSFER_CONTROL_BYTE1 = 8'h5A;
    localparam logic [7:0] TRANSFER_CONTROL_BYTE2 = 8'hC3;
    localparam logic [7:0] TRANSFER_CONTROL_BYTE3 = 8'h7E;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_GAP    = 2'd3;

endpackage

// File: rtl/transfer_byte_fifo.sv
// Single-clock byte FIFO with 2**DEPTH_LOG2 entries and combinational read port.
module transfer_byte_fifo
    import transfer_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  rd_en,
    output logic [7:0]            rd_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_wr;
    logic                  do_rd;

    assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_wr && !do_rd) begin
                count <= count + 1'b1;
            end else if (!do_wr && do_rd) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/transfer_in_byte_feeder.sv
// Buffers host bytes and replays each with a paced RECEIVED strobe (setup, high, low gap).
// Optional FIFO_LEVEL / FIFO_HIGH_WATER ports when FEEDER_LEVEL_EN is defined.
module transfer_in_byte_feeder
    import transfer_pkg::*;
#(
    parameter int DEPTH_LOG2  = 4,
    parameter int HIGH_CYCLES = 2,
    parameter int LOW_CYCLES  = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                BYTE_IN_VALID,
    input  logic [7:0]          BYTE_IN,
    output logic                BYTE_IN_READY,
    output logic                TRANSFER_IN_RECEIVED,
    output logic [7:0]          TRANSFER_IN_BYTE
`ifdef FEEDER_LEVEL_EN
    ,
    output logic [DEPTH_LOG2:0] FIFO_LEVEL,
    output logic                FIFO_HIGH_WATER
`endif
);

    if (HIGH_CYCLES < 1 || HIGH_CYCLES > 255 ||
        LOW_CYCLES < 1 || LOW_CYCLES > 255) begin : g_bad_pacing
        $error("HIGH_CYCLES and LOW_CYCLES must be in 1..255");
    end

    localparam logic [7:0] HIGH_INIT = 8'(HIGH_CYCLES - 1);
    localparam logic [7:0] LOW_INIT  = 8'(LOW_CYCLES - 1);

    logic [1:0]          state;
    logic [7:0]          pace_cnt;
    logic                pop;
    logic [7:0]          fifo_rd_data;
    logic [DEPTH_LOG2:0] fifo_count;
    logic                fifo_full;
    logic                fifo_empty;

    assign BYTE_IN_READY = !fifo_full;
    // Registered occupancy gates the pop, so a byte written this edge waits one clock.
    assign pop = (state == ST_IDLE) && !fifo_empty;

    transfer_byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (BYTE_IN_VALID),
        .wr_data (BYTE_IN),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state                <= ST_IDLE;
            pace_cnt             <= '0;
            TRANSFER_IN_RECEIVED <= 1'b0;
            TRANSFER_IN_BYTE     <= 8'h00;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (fifo_count != '0) begin
                        TRANSFER_IN_BYTE <= fifo_rd_data;
                        state            <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    TRANSFER_IN_RECEIVED <= 1'b1;
                    pace_cnt             <= HIGH_INIT;
                    state                <= ST_STROBE;
                end
                ST_STROBE: begin
                    if (pace_cnt == '0) begin
                        TRANSFER_IN_RECEIVED <= 1'b0;
                        pace_cnt             <= LOW_INIT;
                        state                <= ST_GAP;
                    end else begin
                        pace_cnt <= pace_cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (pace_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        pace_cnt <= pace_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef FEEDER_LEVEL_EN
    assign FIFO_LEVEL = fifo_count;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            FIFO_HIGH_WATER <= 1'b0;
        end else if (fifo_full) begin
            FIFO_HIGH_WATER <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_transfer_in_byte_feeder.sv
// Self-checking bench for transfer_in_byte_feeder: byte order, strobe timing, full and reset.
module tb_transfer_in_byte_feeder;
    import transfer_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       BYTE_IN_VALID = 1'b0;
    logic [7:0] BYTE_IN = 8'h00;
    logic       BYTE_IN_READY;
    logic       TRANSFER_IN_RECEIVED;
    logic [7:0] TRANSFER_IN_BYTE;
`ifdef FEEDER_LEVEL_EN
    logic [4:0] FIFO_LEVEL;
    logic       FIFO_HIGH_WATER;
`endif

    transfer_in_byte_feeder dut (
        .CLK                  (CLK),
        .RST                  (RST),
        .BYTE_IN_VALID        (BYTE_IN_VALID),
        .BYTE_IN              (BYTE_IN),
        .BYTE_IN_READY        (BYTE_IN_READY),
        .TRANSFER_IN_RECEIVED (TRANSFER_IN_RECEIVED),
        .TRANSFER_IN_BYTE     (TRANSFER_IN_BYTE)
`ifdef FEEDER_LEVEL_EN
        ,
        .FIFO_LEVEL           (FIFO_LEVEL),
        .FIFO_HIGH_WATER      (FIFO_HIGH_WATER)
`endif
    );

    always #5 CLK = ~CLK;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          stable_viol = 0;
    int          max_level = 0;
    bit          saw_full = 0;
    logic        prev_rcv = 1'b0;
    logic [7:0]  prev_byte = 8'h00;
    logic [7:0]  exp_q [$];
    logic [7:0]  rx_q [$];
    int          rise_q [$];

    always @(posedge CLK) cyc++;

    // Observer: records each rising strobe with its byte and cycle.
    always @(negedge CLK) begin
        if (TRANSFER_IN_RECEIVED === 1'b1 && prev_rcv !== 1'b1) begin
            rx_q.push_back(TRANSFER_IN_BYTE);
            rise_q.push_back(cyc);
        end
        if (TRANSFER_IN_RECEIVED === 1'b1 && prev_rcv === 1'b1 &&
            TRANSFER_IN_BYTE !== prev_byte)
            stable_viol++;
        prev_rcv  = TRANSFER_IN_RECEIVED;
        prev_byte = TRANSFER_IN_BYTE;
`ifdef FEEDER_LEVEL_EN
        if (int'(FIFO_LEVEL) > max_level) max_level = int'(FIFO_LEVEL);
`endif
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        int guard = 0;
        BYTE_IN_VALID = 1'b1;
        BYTE_IN       = b;
        forever begin
            @(negedge CLK);
            if (BYTE_IN_READY === 1'b1) break;
            saw_full = 1;
`ifdef FEEDER_LEVEL_EN
            chk("level_when_full", 32'(FIFO_LEVEL), 32'd16);
`endif
            guard++;
            if (guard > 200) begin
                chk("push_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge CLK);
        #1;
        exp_q.push_back(b);
        BYTE_IN_VALID = 1'b0;
    endtask

    task automatic wait_rx(input int target, input int budget);
        int k = 0;
        while (rx_q.size() < target && k < budget) begin
            @(negedge CLK);
            k++;
        end
        chk("rx_timeout", 32'(rx_q.size() >= target), 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        int base;
        logic [7:0] last;

        // Reset state
        #12;
        chk("reset_rcv", 32'(TRANSFER_IN_RECEIVED), 32'd0);
        chk("reset_byte", 32'(TRANSFER_IN_BYTE), 32'h00);
        chk("reset_ready", 32'(BYTE_IN_READY), 32'd1);
        RST = 1'b1;
        idle_cycles(3);
`ifdef FEEDER_LEVEL_EN
        chk("reset_level", 32'(FIFO_LEVEL), 32'd0);
        chk("reset_hw", 32'(FIFO_HIGH_WATER), 32'd0);
`endif

        // T2: single byte timing relative to write edge E0
        push(8'h11);
        @(negedge CLK);
        chk("t2_byte_e0", 32'(TRANSFER_IN_BYTE), 32'h00);
        for (int k = 1; k <= 6; k++) begin
            @(negedge CLK);
            chk($sformatf("t2_rcv_e%0d", k), 32'(TRANSFER_IN_RECEIVED),
                32'(k == 2 || k == 3));
            chk($sformatf("t2_byte_e%0d", k), 32'(TRANSFER_IN_BYTE), 32'h11);
        end

        // T3: header burst back-to-back, strobes evenly paced
        idle_cycles(2);
        base = rx_q.size();
        push(TRANSFER_CONTROL_BYTE1);
        push(TRANSFER_CONTROL_BYTE2);
        push(TRANSFER_CONTROL_BYTE3);
        push(8'h0F);
        wait_rx(base + 4, 60);
        if (rx_q.size() >= base + 4) begin
            chk("t3_b0", 32'(rx_q[base]), 32'h5A);
            chk("t3_b3", 32'(rx_q[base+3]), 32'h0F);
            for (int i = 1; i < 4; i++)
                chk($sformatf("t3_gap%0d", i),
                    32'(rise_q[base+i] - rise_q[base+i-1]), 32'd6);
        end

        // T6: write into empty FIFO while FSM is idle
        idle_cycles(10);
        last = TRANSFER_IN_BYTE;
        push(8'hA5);
        @(negedge CLK);
        chk("t6_no_pop_e0", 32'(TRANSFER_IN_BYTE), 32'(last));
        @(negedge CLK);
        chk("t6_load_e1", 32'(TRANSFER_IN_BYTE), 32'hA5);
        chk("t6_rcv_e1", 32'(TRANSFER_IN_RECEIVED), 32'd0);
        @(negedge CLK);
        chk("t6_rcv_e2", 32'(TRANSFER_IN_RECEIVED), 32'd1);

        // T4: overrun the pacer until the FIFO reports full
        idle_cycles(8);
        saw_full = 0;
        for (int i = 0; i < 30; i++) push(8'(i));
        chk("t4_saw_full", 32'(saw_full), 32'd1);
`ifdef FEEDER_LEVEL_EN
        chk("t4_high_water", 32'(FIFO_HIGH_WATER), 32'd1);
`endif
        wait_rx(exp_q.size(), 400);

        // T5: 40 bytes with random VALID gaps
        idle_cycles(3);
        for (int i = 0; i < 40; i++) begin
            push(8'(i));
            idle_cycles($urandom_range(0, 3));
        end
        wait_rx(exp_q.size(), 400);
`ifdef FEEDER_LEVEL_EN
        chk("t5_max_level", 32'(max_level <= 16), 32'd1);
`endif

        // Whole-run ordering: every accepted byte strobed once, in order
        chk("stream_len", 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk($sformatf("stream_%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
        chk("byte_stable_under_strobe", 32'(stable_viol), 32'd0);

        // T1: asynchronous reset mid-stream
        idle_cycles(2);
        for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i));
        begin
            int k = 0;
            while (TRANSFER_IN_RECEIVED !== 1'b1 && k < 40) begin
                @(negedge CLK);
                k++;
            end
        end
        chk("t1_strobing", 32'(TRANSFER_IN_RECEIVED), 32'd1);
        @(negedge CLK);
        #2;
        RST = 1'b0;
        #1;
        chk("t1_rcv_async", 32'(TRANSFER_IN_RECEIVED), 32'd0);
        chk("t1_byte_async", 32'(TRANSFER_IN_BYTE), 32'h00);
        chk("t1_ready", 32'(BYTE_IN_READY), 32'd1);
`ifdef FEEDER_LEVEL_EN
        chk("t1_level", 32'(FIFO_LEVEL), 32'd0);
        chk("t1_hw_clear", 32'(FIFO_HIGH_WATER), 32'd0);
`endif
        idle_cycles(2);
        RST = 1'b1;
        base = rx_q.size();
        idle_cycles(30);
        chk("t1_no_strobe_after", 32'(rx_q.size()), 32'(base));
        chk("t1_rcv_low", 32'(TRANSFER_IN_RECEIVED), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
